twiddle_ctrl: RTL

Twiddle sequencer for one stage of the 32-point MDC FFT. Tracks the sample-pair index within each frame and drives the stage's complex multiplier: the twiddle ROM address and the multiply/bypass mode select. One instance per stage, placed between the stage's input valid/frame-start strobes and its multiplier/ROM. It also reports frame boundaries, counts completed frames and flags frame-sync errors.

---
 rtl/twiddle_ctrl.sv | 68 ++++++
 1 files changed

// File: rtl/twiddle_ctrl.sv
// Twiddle sequencer for one MDC FFT stage: pair index -> ROM exponent + multiply/bypass select.
// Latency 1 cycle, all outputs registered; no backpressure, a pair is accepted on every in_valid.
// Optional macro TWC_TRIVIAL_BYPASS_EN bypasses the multiplier whenever the exponent is 0.
module twiddle_ctrl #(
  parameter int N      = 32,
  parameter int STAGE  = 0,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_sof,
  output logic              out_valid,
  output logic              out_sof,
  output logic              out_eof,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              mul_mode,
  output logic [7:0]        frame_cnt,
  output logic              sync_err
);

  localparam int HALF = N / 2;
  localparam int G    = N >> (STAGE + 1);
  localparam logic [ADDR_W-1:0] GRP_MASK = ADDR_W'(G - 1);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(HALF - 1);

  logic [ADDR_W-1:0] k;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] expo;

  // G is a power of two, so idx mod G is a mask; k wraps naturally at N/2 = 2^ADDR_W.
  always_comb begin
    idx  = in_sof ? '0 : k;
    expo = (idx & GRP_MASK) << STAGE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k         <= '0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
      rom_addr  <= '0;
      mul_mode  <= 1'b1;
      frame_cnt <= 8'd0;
      sync_err  <= 1'b0;
    end else begin
      out_valid <= in_valid;
      out_sof   <= in_valid && (idx == '0);
      out_eof   <= in_valid && (idx == LAST_IDX);
      if (in_valid) begin
        k        <= idx + 1'b1;
        rom_addr <= expo;
`ifdef TWC_TRIVIAL_BYPASS_EN
        mul_mode <= (expo == '0);
`else
        mul_mode <= 1'b0;
`endif
        if (idx == LAST_IDX)
          frame_cnt <= frame_cnt + 8'd1;
        // A frame start that lands on a wrap boundary is legitimate, not an error.
        if (in_sof && (k != '0))
          sync_err <= 1'b1;
      end
    end
  end

endmodule
